// File: rtl/auth_exchange_sequencer.sv
// auth_exchange_sequencer
//   Sequences one USB Type-C authentication exchange on the initiator side:
//   GET_DIGESTS, then CERT_CHUNKS x GET_CERTIFICATE, then CHALLENGE. Each
//   request is issued over valid/ready, then its response is awaited under a
//   timeout. A timed-out request is re-issued up to MAX_RETRY times. The
//   result is reported as a one-cycle done or fail pulse, with a held cause
//   code.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   start, abort         begin exchange (IDLE only) / terminate exchange
//   req_valid/req_ready  request handshake; req_type, req_index describe it
//   resp_valid           one-cycle response pulse with resp_type, resp_ok
//   busy                 exchange in progress
//   done, fail           one-cycle completion pulses
//   fail_code            failure cause, held until the next accepted start
module auth_exchange_sequencer #(
  parameter int unsigned RESP_TIMEOUT = 1000,
  parameter int unsigned MAX_RETRY    = 2,
  parameter int unsigned CERT_CHUNKS  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       req_valid,
  input  logic       req_ready,
  output logic [1:0] req_type,
  output logic [7:0] req_index,
  input  logic       resp_valid,
  input  logic [1:0] resp_type,
  input  logic       resp_ok,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [2:0] fail_code
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StFail} state_e;

  localparam logic [1:0] TypeDigests   = 2'd0;
  localparam logic [1:0] TypeCert      = 2'd1;
  localparam logic [1:0] TypeChallenge = 2'd2;

  localparam logic [2:0] CodeNone    = 3'd0;
  localparam logic [2:0] CodeTimeout = 3'd1;
  localparam logic [2:0] CodeErrResp = 3'd2;
  localparam logic [2:0] CodeBadType = 3'd3;
  localparam logic [2:0] CodeAbort   = 3'd4;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax      = {CNT_W{1'b1}};
  localparam logic [7:0]       LastChunk   = 8'(CERT_CHUNKS - 1);
  localparam logic [7:0]       MaxRetry    = 8'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [1:0]       req_type_q, req_type_d;
  logic [7:0]       req_index_q, req_index_d;
  logic [7:0]       retry_q, retry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fail_code_q, fail_code_d;
  logic             req_valid_q, req_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  always_comb begin
    state_d     = state_q;
    req_type_d  = req_type_q;
    req_index_d = req_index_q;
    retry_d     = retry_q;
    cnt_d       = cnt_q;
    fail_code_d = fail_code_q;

    unique case (state_q)
      StIdle: begin
        // start beats a simultaneous abort: there is nothing to abort yet
        if (start) begin
          state_d     = StIssue;
          req_type_d  = TypeDigests;
          req_index_d = 8'd0;
          retry_d     = 8'd0;
          fail_code_d = CodeNone;
        end
      end
      StIssue: begin
        // No timeout while the initiator stalls the handshake
        if (abort) begin
          state_d     = StFail;
          fail_code_d = CodeAbort;
        end else if (req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        if (abort) begin
          state_d     = StFail;
          fail_code_d = CodeAbort;
        end else if (resp_valid) begin
          // A response in the final WAIT cycle still wins over the timeout
          if (resp_type != req_type_q) begin
            state_d     = StFail;
            fail_code_d = CodeBadType;
          end else if (!resp_ok) begin
            state_d     = StFail;
            fail_code_d = CodeErrResp;
          end else begin
            retry_d = 8'd0;
            state_d = StIssue;
            case (req_type_q)
              TypeDigests: begin
                req_type_d  = TypeCert;
                req_index_d = 8'd0;
              end
              TypeCert: begin
                if (req_index_q == LastChunk) begin
                  req_type_d  = TypeChallenge;
                  req_index_d = 8'd0;
                end else begin
                  req_index_d = req_index_q + 8'd1;
                end
              end
              default: state_d = StDone;
            endcase
          end
        end else if (cnt_q == TimeoutLast) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + 8'd1;
            state_d = StIssue;
          end else begin
            state_d     = StFail;
            fail_code_d = CodeTimeout;
          end
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      StFail:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the next-state decode
    req_valid_d = (state_d == StIssue);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    fail_d      = (state_d == StFail);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      req_type_q  <= 2'd0;
      req_index_q <= 8'd0;
      retry_q     <= 8'd0;
      cnt_q       <= '0;
      fail_code_q <= CodeNone;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_type_q  <= req_type_d;
      req_index_q <= req_index_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      fail_code_q <= fail_code_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_type  = req_type_q;
  assign req_index = req_index_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign fail_code = fail_code_q;

endmodule

// File: tb/tb_auth_exchange_sequencer.sv
// Bench for auth_exchange_sequencer: a reactive initiator driven by a per-request
// plan, checked against an expected request list and outcome derived from the
// plan by a simple exchange model.
module tb_auth_exchange_sequencer;

  localparam int unsigned RESP_TIMEOUT = 8;
  localparam int unsigned MAX_RETRY    = 2;
  localparam int unsigned CERT_CHUNKS  = 4;
  localparam int unsigned CNT_W        = 16;
  localparam int          N_REQ        = CERT_CHUNKS + 2;

  // Plan kinds for the request's final attempt
  localparam int KGood = 0, KBadType = 1, KErr = 2, KAbortResp = 3, KAbortIssue = 4;

  logic       clk = 1'b0;
  logic       reset, start, abort, req_ready, resp_valid, resp_ok;
  logic [1:0] resp_type;
  logic       req_valid, busy, done, fail;
  logic [1:0] req_type;
  logic [7:0] req_index;
  logic [2:0] fail_code;

  int tests = 0;
  int fails = 0;

  int p_to    [N_REQ];
  int p_kind  [N_REQ];
  int p_delay [N_REQ];
  int p_stall [N_REQ];

  logic [9:0] exp_q[$];
  int         exp_code;
  bit         exp_done;

  auth_exchange_sequencer #(
    .RESP_TIMEOUT (RESP_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY),
    .CERT_CHUNKS  (CERT_CHUNKS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_type   (req_type),
    .req_index  (req_index),
    .resp_valid (resp_valid),
    .resp_type  (resp_type),
    .resp_ok    (resp_ok),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_code  (fail_code)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required finish");
    $fatal(1);
  end

  // Request r of the exchange as {type, index}
  function automatic logic [9:0] req_of(int r);
    if (r == 0) return {2'd0, 8'd0};
    if (r <= int'(CERT_CHUNKS)) return {2'd1, 8'(r - 1)};
    return {2'd2, 8'd0};
  endfunction

  // Walk the plan: each attempt is one issued request; a timeout beyond the
  // retry allowance, a bad response or an abort ends the exchange.
  function automatic void model();
    bit stop;
    exp_q.delete();
    exp_done = 1'b0;
    exp_code = 0;
    stop     = 1'b0;
    for (int r = 0; r < N_REQ && !stop; r++) begin
      bit next;
      int a;
      next = 1'b0;
      a    = 0;
      while (!next && !stop) begin
        if (a > int'(MAX_RETRY)) begin
          exp_code = 1;
          stop     = 1'b1;
        end else begin
          exp_q.push_back(req_of(r));
          if (a < p_to[r]) a++;
          else if (p_kind[r] == KGood) next = 1'b1;
          else begin
            exp_code = (p_kind[r] == KBadType) ? 3 : (p_kind[r] == KErr) ? 2 : 4;
            stop     = 1'b1;
          end
        end
      end
    end
    exp_done = !stop;
  endfunction

  task automatic plan_good(int delay);
    for (int r = 0; r < N_REQ; r++) begin
      p_to[r]    = 0;
      p_kind[r]  = KGood;
      p_delay[r] = delay;
      p_stall[r] = 0;
    end
  endtask

  task automatic run_exchange(string name);
    int         r, a;
    bit         finished, got_done;
    logic [1:0] t;
    logic [7:0] idx;
    logic [9:0] exp_req;
    logic [2:0] held;
    r = 0; a = 0; finished = 1'b0; got_done = 1'b0;
    model();
    @(negedge clk);
    start = 1'b1;
    abort = 1'($urandom_range(0, 1));  // start must win in IDLE
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int it = 0; it < 64 && !finished; it++) begin
      if (fail) begin
        finished = 1'b1;
      end else if (done) begin
        got_done = 1'b1;
        finished = 1'b1;
      end else if (req_valid && exp_q.size() != 0) begin
        exp_req = exp_q.pop_front();
        tests++;
        if ({req_type, req_index} !== exp_req) begin
          fails++;
          $display("FAIL %s request: got type=%0d index=%0d, required type=%0d index=%0d",
                   name, req_type, req_index, exp_req[9:8], exp_req[7:0]);
        end
        t   = req_type;
        idx = req_index;
        if (r >= N_REQ) r = N_REQ - 1;
        if (a >= p_to[r] && p_kind[r] == KAbortIssue) begin
          abort     = 1'b1;
          req_ready = 1'b1;
          @(negedge clk);
          abort     = 1'b0;
          req_ready = 1'b0;
        end else begin
          for (int s = 0; s < p_stall[r]; s++) begin
            if (s == 0) begin  // stray response while issuing must be ignored
              resp_valid = 1'b1;
              resp_type  = 2'($urandom);
              resp_ok    = 1'($urandom);
            end
            @(negedge clk);
            resp_valid = 1'b0;
            tests++;
            if (req_valid !== 1'b1 || {req_type, req_index} !== {t, idx} || fail !== 1'b0) begin
              fails++;
              $display("FAIL %s stall: got valid=%0b type=%0d index=%0d fail=%0b, required 1 %0d %0d 0",
                       name, req_valid, req_type, req_index, fail, t, idx);
            end
          end
          req_ready = 1'b1;
          @(negedge clk);
          req_ready = 1'b0;
          tests++;
          if (req_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: got valid=%0b busy=%0b, required 0 1", name, req_valid, busy);
          end
          if ($urandom_range(0, 3) == 0) start = 1'b1;  // ignored while busy
          if (a < p_to[r]) begin
            repeat (RESP_TIMEOUT) begin
              @(negedge clk);
              start = 1'b0;
            end
            a++;
          end else begin
            repeat (p_delay[r] - 1) begin
              @(negedge clk);
              start = 1'b0;
            end
            resp_valid = 1'b1;
            resp_ok    = (p_kind[r] != KErr);
            resp_type  = (p_kind[r] == KBadType) ? ((t == 2'd2) ? 2'd1 : 2'd2) : t;
            abort      = (p_kind[r] == KAbortResp);
            @(negedge clk);
            start      = 1'b0;
            resp_valid = 1'b0;
            resp_ok    = 1'b0;
            abort      = 1'b0;
            if (p_kind[r] == KGood) begin
              r++;
              a = 0;
            end
          end
        end
      end else begin
        tests++;
        fails++;
        $display("FAIL %s progress: got valid=%0b busy=%0b done=%0b fail=%0b, required request or end",
                 name, req_valid, busy, done, fail);
        finished = 1'b1;
      end
    end
    tests++;
    if (!finished) begin
      fails++;
      $display("FAIL %s budget: exchange did not end, required end within budget", name);
    end
    tests++;
    if (got_done !== exp_done || fail_code !== 3'(exp_code) || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s outcome: got done=%0b code=%0d busy=%0b, required done=%0b code=%0d busy=1",
               name, got_done, fail_code, busy, exp_done, exp_code);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s request_count: got %0d requests missing, required 0", name, exp_q.size());
    end
    held = fail_code;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0 || req_valid !== 1'b0 ||
        fail_code !== held) begin
      fails++;
      $display("FAIL %s idle_after: got busy=%0b done=%0b fail=%0b valid=%0b code=%0d, required 0 0 0 0 %0d",
               name, busy, done, fail, req_valid, fail_code, held);
    end
  endtask

  task automatic check_outputs_zero(string name);
    tests++;
    if (req_valid !== 1'b0 || req_type !== 2'd0 || req_index !== 8'd0 || busy !== 1'b0 ||
        done !== 1'b0 || fail !== 1'b0 || fail_code !== 3'd0) begin
      fails++;
      $display("FAIL %s: got valid=%0b type=%0d index=%0d busy=%0b done=%0b fail=%0b code=%0d, required all 0",
               name, req_valid, req_type, req_index, busy, done, fail, fail_code);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_type = 2'd0; resp_ok = 1'b0;
    #2;
    check_outputs_zero("reset_async");
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_held");
    reset = 1'b0;
  endtask

  task automatic test_nominal();
    plan_good(5);
    run_exchange("nominal");
  endtask

  task automatic test_timeout_fail();
    plan_good(5);
    p_to[0] = MAX_RETRY + 1;
    run_exchange("timeout_fail");
  endtask

  task automatic test_retry_recover();
    plan_good(3);
    p_to[1]    = 1;
    p_to[4]    = 1;
    p_delay[4] = RESP_TIMEOUT;  // response in the final WAIT cycle
    run_exchange("retry_recover");
  endtask

  task automatic test_bad_responses();
    plan_good(2);
    p_kind[0] = KBadType;
    run_exchange("bad_type");
    plan_good(2);
    p_kind[3] = KErr;  // GET_CERTIFICATE index 2
    run_exchange("error_resp");
  endtask

  task automatic test_abort();
    plan_good(4);
    p_kind[0] = KAbortResp;
    run_exchange("abort_with_resp");
    plan_good(4);
    p_kind[2] = KAbortIssue;
    run_exchange("abort_with_handshake");
  endtask

  task automatic test_ready_stall();
    plan_good(2);
    p_stall[0] = 50;
    run_exchange("ready_stall");
  endtask

  task automatic test_async_reset_mid_wait();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_outputs_zero("reset_mid_wait");
    @(negedge clk);
    reset = 1'b0;
    plan_good(2);
    run_exchange("restart_after_reset");
  endtask

  task automatic test_random();
    for (int e = 0; e < 40; e++) begin
      for (int r = 0; r < N_REQ; r++) begin
        int k;
        p_to[r]    = ($urandom_range(0, 7) == 0) ? $urandom_range(1, MAX_RETRY + 1) : 0;
        k          = $urandom_range(0, 24);
        p_kind[r]  = (k < 4) ? k + 1 : KGood;
        p_delay[r] = $urandom_range(1, RESP_TIMEOUT);
        p_stall[r] = $urandom_range(0, 2);
      end
      run_exchange("random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout_fail();
    test_retry_recover();
    test_bad_responses();
    test_abort();
    test_ready_stall();
    test_async_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/auth_exchange_sequencer.md
Name: auth_exchange_sequencer

Overview:
- Controls the authentication initiator datapath by sequencing one USB Type-C authentication exchange: GET_DIGESTS, then N GET_CERTIFICATE chunks, then CHALLENGE.
- Issues each request over a valid/ready handshake and waits for the matching response under a response timeout.
- Retries a timed-out request a bounded number of times.
- Reports done or fail with a cause code to the policy layer above.

Parameters:
RESP_TIMEOUT, 1000, cycles allowed between request acceptance and its response
MAX_RETRY, 2, re-issues allowed per request after timeout (0 = no retry)
CERT_CHUNKS, 4, number of GET_CERTIFICATE requests (1..255)
CNT_W, 16, width of the timeout counter (must hold RESP_TIMEOUT)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begin exchange (accepted only in IDLE)
abort  in  1  level; terminate current exchange
req_valid  out  1  request presented to initiator
req_ready  in  1  initiator accepts request
req_type  out  2  0=GET_DIGESTS, 1=GET_CERTIFICATE, 2=CHALLENGE
req_index  out  8  certificate chunk index (0 for other types)
resp_valid  in  1  one-cycle response pulse from initiator
resp_type  in  2  type the response answers
resp_ok  in  1  1=good response, 0=error response
busy  out  1  exchange in progress
done  out  1  one-cycle pulse, exchange succeeded
fail  out  1  one-cycle pulse, exchange failed
fail_code  out  3  cause, held until next start: 0 none, 1 timeout, 2 error resp, 3 unexpected type, 4 abort

Behaviour:
- Reset (async, any state): state=IDLE; req_valid=0, req_type=0, req_index=0, busy=0, done=0, fail=0, fail_code=0; retry counter, chunk counter and timeout counter=0.
- States: IDLE, ISSUE, WAIT, DONE, FAIL.
- IDLE:
  - start=1 -> ISSUE with req_type=0, req_index=0, retry=0, fail_code=0.
  - busy=0 in IDLE only.
- ISSUE:
  - req_valid=1; req_type/req_index stay stable until the handshake.
  - req_valid&req_ready -> WAIT next cycle; req_valid drops that cycle; timeout counter cleared to 0.
  - No timeout runs in ISSUE; the handshake may stall indefinitely.
- WAIT:
  - Counter increments each cycle with no resp_valid.
  - Counter reaching RESP_TIMEOUT-1 without a response = timeout. The timeout fires on the RESP_TIMEOUT-th WAIT cycle; a response in that cycle still counts as a response.
  - Timeout with retry<MAX_RETRY: retry+1, back to ISSUE with the same type/index.
  - Timeout with retry==MAX_RETRY: FAIL, code 1.
- resp_valid in WAIT, checked in priority order:
  - resp_type!=req_type -> FAIL, code 3.
  - resp_ok=0 -> FAIL, code 2.
  - Otherwise advance and reset retry=0:
    - GET_DIGESTS -> ISSUE GET_CERTIFICATE, index 0.
    - GET_CERTIFICATE with index<CERT_CHUNKS-1 -> ISSUE, index+1.
    - Last chunk -> ISSUE CHALLENGE, index 0.
    - CHALLENGE -> DONE.
- resp_valid outside WAIT is ignored, with no state or code change.
- DONE: done=1 for exactly one cycle, then IDLE.
- FAIL: fail=1 for exactly one cycle, fail_code updated the same cycle, then IDLE. fail_code holds until the next accepted start.
- abort=1 in ISSUE or WAIT -> FAIL, code 4, next cycle. Abort takes priority over a simultaneous handshake, response or timeout. abort in IDLE/DONE/FAIL is ignored.
- start while busy is ignored; start and abort both high in IDLE -> start wins (abort not yet meaningful).
- Latency:
  - start to first req_valid: 1 cycle.
  - Accepted good response to next req_valid: 1 cycle.
  - Final good CHALLENGE response to done: 1 cycle.
- busy=1 in ISSUE, WAIT, DONE, FAIL.
- Counter saturates; it never wraps.

Test Plan:
- Nominal, CERT_CHUNKS=4, initiator ready=1, good response 5 cycles after each accept -> 6 requests observed (types 0,1,1,1,1,2; indices 0,0,1,2,3,0); done pulses once; fail_code=0; busy falls the cycle after done.
- RESP_TIMEOUT=8, MAX_RETRY=2, no responses to GET_DIGESTS -> GET_DIGESTS issued 3 times; fail on the 8th WAIT cycle of the third attempt; fail_code=1.
- First GET_CERTIFICATE times out once, retry answered good -> index-0 request repeated once; sequence then completes with done; retry count resets so a later single timeout also recovers.
- Response with resp_type=2 while waiting on GET_DIGESTS -> fail, code 3. Separately, GET_CERTIFICATE index 2 answered with resp_ok=0 -> fail, code 2; no CHALLENGE issued.
- abort asserted in the same cycle as a good resp_valid in WAIT -> fail, code 4, next cycle; no further req_valid. req_ready held low for 50 cycles in ISSUE -> req_valid and fields stable, no timeout.
- Reset asserted mid-WAIT (asynchronously, between edges) -> all outputs 0 immediately. A new start after release restarts from GET_DIGESTS index 0.
